mem_arbiter: RTL and testbench

Two-port arbiter that lets the instruction cache and the data cache share the single main-memory port. Each cache connects its memory-side interface (request, write-data and response channels) to one requester port of this block. The block owns the memory port and does the following:
- grants it to one cache at a time, round-robin;
- holds the grant for the whole miss transaction, including all outstanding read beats;
- routes memory responses back to the owner only.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one main-memory port between the instruction and data caches
module mem_arbiter #(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                   ic_mem_req_rw,
    input  logic                   ic_mem_req_data_valid,
    output logic                   ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                   ic_mem_resp_valid,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,
    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                   dc_mem_req_rw,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,
    output logic [1:0]             grant,
    output logic                   err_spurious
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, OWN_IC, OWN_DC} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_dc;
    logic          own_ic, own_dc, cap, owner_valid, inc, dec;

    assign own_ic      = (state == OWN_IC);
    assign own_dc      = (state == OWN_DC);
    assign grant       = {own_dc, own_ic};
    assign cap         = (cnt == CW'(MAX_OUTSTANDING));
    assign owner_valid = own_ic ? ic_mem_req_valid : own_dc & dc_mem_req_valid;

    // owner's request and write-data channels steer straight onto the memory port
    always_comb begin
        mem_req_valid         = owner_valid & ~cap;
        mem_req_addr          = own_ic ? ic_mem_req_addr : own_dc ? dc_mem_req_addr : '0;
        mem_req_rw            = own_ic ? ic_mem_req_rw : own_dc & dc_mem_req_rw;
        mem_req_data_valid    = own_ic ? ic_mem_req_data_valid : own_dc & dc_mem_req_data_valid;
        mem_req_data_bits     = own_ic ? ic_mem_req_data_bits : own_dc ? dc_mem_req_data_bits : '0;
        mem_req_data_mask     = own_ic ? ic_mem_req_data_mask : own_dc ? dc_mem_req_data_mask : '0;
        ic_mem_req_ready      = own_ic & mem_req_ready & ~cap;
        dc_mem_req_ready      = own_dc & mem_req_ready & ~cap;
        ic_mem_req_data_ready = own_ic & mem_req_data_ready;
        dc_mem_req_data_ready = own_dc & mem_req_data_ready;
        ic_mem_resp_valid     = own_ic & dec;
        dc_mem_resp_valid     = own_dc & dec;
        ic_mem_resp_data      = mem_resp_data;
        dc_mem_resp_data      = mem_resp_data;
    end

    // a response with nothing outstanding is spurious and never counted or forwarded
    always_comb begin
        inc   = mem_req_valid & mem_req_ready & ~mem_req_rw;
        dec   = mem_resp_valid & (cnt != '0);
        cnt_n = cnt + CW'(inc) - CW'(dec);
    end

    // arbitrate only from IDLE; hold ownership until the owner is idle and all reads are answered
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (ic_mem_req_valid && dc_mem_req_valid) state_n = last_dc ? OWN_IC : OWN_DC;
                else if (ic_mem_req_valid) state_n = OWN_IC;
                else if (dc_mem_req_valid) state_n = OWN_DC;
            end
            OWN_IC: if (!ic_mem_req_valid && cnt_n == '0) state_n = IDLE;
            OWN_DC: if (!dc_mem_req_valid && cnt_n == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, outstanding count, round-robin pointer and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_dc      <= 1'b1;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            err_spurious <= err_spurious | (mem_resp_valid & (cnt == '0));
            if (state == IDLE && state_n != IDLE) last_dc <= (state_n == OWN_DC);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ic_valid = 0, ic_rw = 0, ic_dv = 0;
    logic [27:0]  ic_addr = '0;
    logic [127:0] ic_bits = '0;
    logic [15:0]  ic_mask = '0;
    logic         dc_valid = 0, dc_rw = 0, dc_dv = 0;
    logic [27:0]  dc_addr = '0;
    logic [127:0] dc_bits = '0;
    logic [15:0]  dc_mask = '0;
    logic         mem_ready = 1, mem_dready = 1, mem_rvalid = 0;
    logic [127:0] mem_rdata = '0;
    logic         ic_ready, ic_dready, ic_rvalid, dc_ready, dc_dready, dc_rvalid;
    logic [127:0] ic_rdata, dc_rdata, m_bits;
    logic         m_valid, m_rw, m_dv, err;
    logic [27:0]  m_addr;
    logic [15:0]  m_mask;
    logic [1:0]   grant;
    int           ncmp = 0, nerr = 0, npulse = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_mem_req_valid(ic_valid), .ic_mem_req_ready(ic_ready), .ic_mem_req_addr(ic_addr),
        .ic_mem_req_rw(ic_rw), .ic_mem_req_data_valid(ic_dv), .ic_mem_req_data_ready(ic_dready),
        .ic_mem_req_data_bits(ic_bits), .ic_mem_req_data_mask(ic_mask),
        .ic_mem_resp_valid(ic_rvalid), .ic_mem_resp_data(ic_rdata),
        .dc_mem_req_valid(dc_valid), .dc_mem_req_ready(dc_ready), .dc_mem_req_addr(dc_addr),
        .dc_mem_req_rw(dc_rw), .dc_mem_req_data_valid(dc_dv), .dc_mem_req_data_ready(dc_dready),
        .dc_mem_req_data_bits(dc_bits), .dc_mem_req_data_mask(dc_mask),
        .dc_mem_resp_valid(dc_rvalid), .dc_mem_resp_data(dc_rdata),
        .mem_req_valid(m_valid), .mem_req_ready(mem_ready), .mem_req_addr(m_addr),
        .mem_req_rw(m_rw), .mem_req_data_valid(m_dv), .mem_req_data_ready(mem_dready),
        .mem_req_data_bits(m_bits), .mem_req_data_mask(m_mask),
        .mem_resp_valid(mem_rvalid), .mem_resp_data(mem_rdata),
        .grant(grant), .err_spurious(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        ic_valid = 1;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_ic_ready", ic_ready, 0);
        chk("rst_err", err, 0);
        ic_valid = 0;
        reset = 1;
        tick();
        // single IC read miss
        ic_valid = 1;
        ic_addr = 28'h100;
        #1;
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_mvalid", m_valid, 0);
        chk("t1_idle_ready", ic_ready, 0);
        tick();
        for (int k = 0; k <= 6; k++) begin
            ic_valid = (k < 4);
            ic_addr = 28'h100 + 28'(k);
            mem_rvalid = (k >= 2 && k <= 5);
            mem_rdata = 128'hA0 + 128'(k);
            #1;
            chk("t1_grant", grant, (k <= 5) ? 2'b01 : 2'b00);
            chk("t1_ic_rvalid", ic_rvalid, (k >= 2 && k <= 5));
            chk("t1_dc_ready", dc_ready, 0);
            chk("t1_dc_rvalid", dc_rvalid, 0);
            npulse += int'(ic_rvalid);
            if (k == 0) begin
                chk("t1_mvalid", m_valid, 1);
                chk("t1_maddr", m_addr, 28'h100);
            end
            if (k == 3) chk("t1_rdata", ic_rdata, 128'hA3);
            if (k == 4) chk("t1_cnt_simul", dut.cnt, 2);
            tick();
        end
        mem_rvalid = 0;
        chk("t1_pulses", npulse, 4);
        // tie after reset goes to IC, next tie to DC
        reset = 0;
        #1;
        reset = 1;
        ic_valid = 1;
        dc_valid = 1;
        #1;
        chk("t2_idle", grant, 0);
        tick();
        chk("t2_first_ic", grant, 2'b01);
        ic_valid = 0;
        #1;
        chk("t2_mvalid_low", m_valid, 0);
        tick();
        chk("t2_gap_idle", grant, 2'b00);
        ic_valid = 1;
        #1;
        chk("t2_gap_ic_ready", ic_ready, 0);
        tick();
        chk("t2_then_dc", grant, 2'b10);
        ic_valid = 0;
        // DC dirty write
        dc_rw = 1;
        dc_dv = 1;
        dc_addr = 28'h200;
        dc_bits = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        dc_mask = 16'h00FF;
        #1;
        chk("t4_mvalid", m_valid, 1);
        chk("t4_rw", m_rw, 1);
        chk("t4_addr", m_addr, 28'h200);
        chk("t4_dv", m_dv, 1);
        chk("t4_bits", m_bits, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        chk("t4_mask", m_mask, 16'h00FF);
        chk("t4_dready", dc_dready, 1);
        chk("t4_ready", dc_ready, 1);
        tick();
        chk("t4_cnt_write", dut.cnt, 0);
        dc_rw = 0;
        dc_dv = 0;
        // DC refill hitting the outstanding cap
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_accept", m_valid, 1);
            tick();
        end
        chk("t3_cnt4", dut.cnt, 4);
        chk("t3_cap_mvalid", m_valid, 0);
        chk("t3_cap_ready", dc_ready, 0);
        tick();
        mem_rvalid = 1;
        mem_rdata = 128'h77;
        #1;
        chk("t3_dc_rvalid", dc_rvalid, 1);
        chk("t3_dc_rdata", dc_rdata, 128'h77);
        chk("t3_ic_rvalid", ic_rvalid, 0);
        chk("t3_still_cap", m_valid, 0);
        tick();
        mem_rvalid = 0;
        #1;
        chk("t3_cnt3", dut.cnt, 3);
        chk("t3_fifth_valid", m_valid, 1);
        chk("t3_fifth_ready", dc_ready, 1);
        tick();
        chk("t3_cnt4b", dut.cnt, 4);
        // drain with IC waiting: IC blocked until refill finishes
        dc_valid = 0;
        ic_valid = 1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1;
            #1;
            chk("t4_blocked_grant", grant, 2'b10);
            chk("t4_blocked_ready", ic_ready, 0);
            tick();
        end
        mem_rvalid = 0;
        #1;
        chk("t4_release", grant, 2'b00);
        chk("t4_cnt0", dut.cnt, 0);
        tick();
        chk("t4_ic_granted", grant, 2'b01);
        ic_valid = 0;
        tick();
        // spurious response in IDLE
        mem_rvalid = 1;
        #1;
        chk("t5_no_ic", ic_rvalid, 0);
        chk("t5_no_dc", dc_rvalid, 0);
        chk("t5_err_before", err, 0);
        tick();
        mem_rvalid = 0;
        #1;
        chk("t5_err", err, 1);
        chk("t5_cnt", dut.cnt, 0);
        // async reset mid-refill with two reads outstanding
        ic_valid = 1;
        ic_addr = 28'h300;
        tick();
        tick();
        tick();
        chk("t6_cnt2", dut.cnt, 2);
        chk("t6_grant", grant, 2'b01);
        reset = 0;
        mem_rvalid = 1;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_mvalid", m_valid, 0);
        chk("t6_rst_ready", ic_ready, 0);
        chk("t6_rst_addr", m_addr, 0);
        chk("t6_rst_rvalid", ic_rvalid, 0);
        chk("t6_rst_err", err, 0);
        tick();
        reset = 1;
        ic_valid = 0;
        #1;
        chk("t6_post_grant", grant, 0);
        chk("t6_post_cnt", dut.cnt, 0);
        chk("t6_late_rvalid", ic_rvalid, 0);
        tick();
        mem_rvalid = 0;
        chk("t6_late_err", err, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
